i2c_slave_core: RTL and testbench

Synthesizable I2C slave protocol engine that services the testbench I2C slave model's TX/RX byte storage. It samples the bus SCL/SDA lines on the system clock and detects START, STOP and repeated START. It matches the 7-bit slave address and pushes master-written bytes into the RX store. It pops bytes from the TX store and shifts them onto SDA for master reads. SDA is open-drain: the block only ever pulls it low or releases it.

---
 rtl/i2c_slave_core.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core.sv
// I2C slave protocol engine: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit
// address and moves bytes between the bus and external RX/TX stores over open-drain SDA.
module i2c_slave_core #(
    parameter int G_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] i2c_slave_addr,
    output logic       rx_wr_en,
    output logic [7:0] rx_wr_data,
    input  logic       rx_full,
    output logic       tx_rd_en,
    input  logic [7:0] tx_rd_data,
    input  logic       tx_empty,
    output logic       busy,
    output logic       tx_underrun,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [G_SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_hist_q, sda_hist_q;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       phase_q, phase_d;   // second scl_fall of an ACK slot, or master ACK seen
    logic       ack_q, ack_d;
    logic       match_q, match_d;
    logic       rw_q, rw_d;
    logic       pend_q, pend_d;
    logic       load;

    // Sync flops idle high so reset release never fakes a bus event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[G_SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[G_SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[G_SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[G_SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            phase_q  <= 1'b0;
            ack_q    <= 1'b0;
            match_q  <= 1'b0;
            rw_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            phase_q  <= phase_d;
            ack_q    <= ack_d;
            match_q  <= match_d;
            rw_q     <= rw_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        phase_d     = phase_q;
        ack_d       = ack_q;
        match_d     = match_q;
        rw_d        = rw_q;
        pend_d      = 1'b0;
        load        = 1'b0;
        rx_wr_en    = 1'b0;
        tx_rd_en    = 1'b0;
        tx_underrun = 1'b0;
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            phase_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shreg_d = {shreg_q[6:0], sda_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd6) match_d = ({shreg_q[5:0], sda_s} == i2c_slave_addr);
                    if (cnt_q == 3'd7) begin
                        rw_d    = sda_s;
                        phase_d = 1'b0;
                        state_d = match_q ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else if (!rw_q) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = WR_DATA;
                    end else begin
                        load = 1'b1;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_d = {shreg_q[6:0], sda_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = WR_ACK;
                        pend_d  = 1'b1;
                        phase_d = 1'b0;
                    end
                end
                WR_ACK: begin
                    if (pend_q) begin
                        ack_d    = ~rx_full;
                        rx_wr_en = ~rx_full;
                    end
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = ack_q;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ack_q ? WR_DATA : WAIT_STOP;
                        end
                    end
                end
                RD_DATA: if (scl_fall) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = WAIT_STOP;
                        else       phase_d = 1'b1;
                    end
                    if (scl_fall && phase_q) load = 1'b1;
                end
                default: ;
            endcase
            // Byte load at the scl_fall that closes an ACK slot.
            if (load) begin
                cnt_d   = '0;
                phase_d = 1'b0;
                state_d = RD_DATA;
                if (tx_empty) begin
                    shreg_d     = 8'hFF;
                    tx_underrun = 1'b1;
                    sda_oe_d    = 1'b0;
                end else begin
                    shreg_d  = tx_rd_data;
                    tx_rd_en = 1'b1;
                    sda_oe_d = ~tx_rd_data[7];
                end
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign rx_wr_data = shreg_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level I2C master, an open-drain bus, RX/TX store models
// and directed plus randomized transfers checked against a transaction-level model.
module tb_i2c_slave_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [6:0] slave_addr = 7'h50;
    logic       rx_wr_en;
    logic [7:0] rx_wr_data;
    logic       rx_full = 1'b0;
    logic       tx_rd_en;
    logic [7:0] tx_rd_data;
    logic       tx_empty;
    logic       busy;
    logic       tx_underrun;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_mem [0:255];
    int tx_head = 0;
    int tx_tail = 0;
    logic [7:0] rx_got[$];
    logic [7:0] exp_q[$];
    int tx_pops = 0;
    int underruns = 0;
    int oe_cycles = 0;
    int rx_wide = 0;
    logic rx_en_prev = 1'b0;

    always #5 clk = ~clk;

    assign sda_in     = sda_m & ~sda_oe;
    assign tx_empty   = (tx_head == tx_tail);
    assign tx_rd_data = tx_mem[tx_head[7:0]];

    i2c_slave_core #(.G_SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
        .i2c_slave_addr(slave_addr), .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data),
        .rx_full(rx_full), .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data),
        .tx_empty(tx_empty), .busy(busy), .tx_underrun(tx_underrun), .dbg_state(dbg_state)
    );

    // The store pops on the same edge that consumes tx_rd_data.
    always @(posedge clk) if (tx_rd_en) tx_head <= tx_head + 1;

    always @(negedge clk) begin
        if (rx_wr_en) rx_got.push_back(rx_wr_data);
        if (rx_wr_en && rx_en_prev) rx_wide++;
        rx_en_prev = rx_wr_en;
        if (tx_rd_en) tx_pops++;
        if (tx_underrun) underruns++;
        if (sda_oe) oe_cycles++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(4); sda_m = b; wait_clk(4); scl_m = 1'b1; wait_clk(8); scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(4); sda_m = 1'b1; wait_clk(4); scl_m = 1'b1;
        wait_clk(4); b = sda_in; wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic bus_start;
        wait_clk(4); sda_m = 1'b1; wait_clk(4); scl_m = 1'b1;
        wait_clk(4); sda_m = 1'b0; wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic bus_stop;
        wait_clk(4); sda_m = 1'b0; wait_clk(4); scl_m = 1'b1;
        wait_clk(4); sda_m = 1'b1; wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    task automatic tx_load(input logic [7:0] d);
        tx_mem[tx_tail[7:0]] = d;
        tx_tail++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_wr_en !== 1'b0) begin errors++; $display("FAIL reset_rx_wr_en: got %b expected 0", rx_wr_en); end
        checks++; if (tx_rd_en !== 1'b0) begin errors++; $display("FAIL reset_tx_rd_en: got %b expected 0", tx_rd_en); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
        checks++; if (rx_wr_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_wr_data); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write;
        logic a0, a1, a2;
        int n0;
        slave_addr = 7'h50;
        n0 = rx_got.size();
        bus_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_on: got %b expected 1", busy); end
        write_byte(8'hA0, a0);
        write_byte(8'hA5, a1);
        write_byte(8'h3C, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (rx_got.size() - n0 !== 2) begin errors++; $display("FAIL write_push_count: got %0d expected 2", rx_got.size() - n0); end
        if (rx_got.size() - n0 == 2) begin
            checks++; if (rx_got[n0] !== 8'hA5) begin errors++; $display("FAIL write_byte0: got %h expected a5", rx_got[n0]); end
            checks++; if (rx_got[n0+1] !== 8'h3C) begin errors++; $display("FAIL write_byte1: got %h expected 3c", rx_got[n0+1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_off: got %b expected 0", busy); end
        checks++; if (rx_wide !== 0) begin errors++; $display("FAIL write_push_width: got %0d wide pulses expected 0", rx_wide); end
    endtask

    task automatic test_addr_mismatch;
        logic a0, a1;
        int oe0, n0;
        oe0 = oe_cycles;
        n0 = rx_got.size();
        bus_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mismatch_busy_on: got %b expected 1", busy); end
        write_byte(8'hA2, a0);
        write_byte(8'h11, a1);
        bus_stop();
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mismatch_nacks: got %b expected 11", {a0, a1}); end
        checks++; if (oe_cycles !== oe0) begin errors++; $display("FAIL mismatch_sda_oe: got %0d oe cycles expected 0", oe_cycles - oe0); end
        checks++; if (rx_got.size() !== n0) begin errors++; $display("FAIL mismatch_push: got %0d pushes expected 0", rx_got.size() - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy_off: got %b expected 0", busy); end
    endtask

    task automatic test_read;
        logic a0;
        logic [7:0] d0, d1;
        int p0, u0;
        tx_tail = tx_head;
        tx_load(8'h12);
        tx_load(8'h34);
        p0 = tx_pops;
        u0 = underruns;
        bus_start();
        write_byte(8'hA1, a0);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        bus_stop();
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", a0); end
        checks++; if (d0 !== 8'h12) begin errors++; $display("FAIL read_byte0: got %h expected 12", d0); end
        checks++; if (d1 !== 8'h34) begin errors++; $display("FAIL read_byte1: got %h expected 34", d1); end
        checks++; if (tx_pops - p0 !== 2) begin errors++; $display("FAIL read_pops: got %0d expected 2", tx_pops - p0); end
        checks++; if (underruns !== u0) begin errors++; $display("FAIL read_underrun: got %0d expected 0", underruns - u0); end
        tx_tail = tx_head;
    endtask

    task automatic test_rx_full;
        logic a0, a1, a2;
        int n0;
        n0 = rx_got.size();
        bus_start();
        write_byte(8'hA0, a0);
        rx_full = 1'b1;
        write_byte(8'h77, a1);
        rx_full = 1'b0;
        write_byte(8'h55, a2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_held: got %b expected 1", busy); end
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b011) begin errors++; $display("FAIL full_acks: got %b expected 011", {a0, a1, a2}); end
        checks++; if (rx_got.size() !== n0) begin errors++; $display("FAIL full_push: got %0d pushes expected 0", rx_got.size() - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_off: got %b expected 0", busy); end
    endtask

    task automatic test_rep_start_underrun;
        logic a0, a1, a2;
        logic [7:0] d;
        int n0, u0, p0;
        tx_tail = tx_head;
        n0 = rx_got.size();
        u0 = underruns;
        p0 = tx_pops;
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h01, a1);
        bus_start();
        write_byte(8'hA1, a2);
        read_byte(d, 1'b1);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rs_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (rx_got.size() - n0 !== 1) begin errors++; $display("FAIL rs_push_count: got %0d expected 1", rx_got.size() - n0); end
        else begin
            checks++; if (rx_got[n0] !== 8'h01) begin errors++; $display("FAIL rs_push_data: got %h expected 01", rx_got[n0]); end
        end
        checks++; if (underruns - u0 !== 1) begin errors++; $display("FAIL rs_underrun: got %0d expected 1", underruns - u0); end
        checks++; if (tx_pops !== p0) begin errors++; $display("FAIL rs_pops: got %0d expected 0", tx_pops - p0); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rs_read_data: got %h expected ff", d); end
    endtask

    task automatic test_reset_mid_read;
        logic a0, b;
        tx_tail = tx_head;
        tx_load(8'h00);
        bus_start();
        write_byte(8'hA1, a0);
        recv_bit(b);
        recv_bit(b);
        wait_clk(4); sda_m = 1'b1; wait_clk(4); scl_m = 1'b1; wait_clk(4);
        #2;
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_oe_before: got %b expected 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_oe_async: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_busy_async: got %b expected 0", busy); end
        wait_clk(2);
        rst_n = 1'b1;
        tx_tail = tx_head;
        wait_clk(10);
        bus_start();
        write_byte(8'hA0, a0);
        bus_stop();
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL midread_reack: got %b expected 0", a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++) begin
            logic [6:0] addr, sent;
            logic match, rw, blocked, full, ack, exp_ack;
            logic [7:0] d, exp_d;
            logic [7:0] ld[$];
            int nb, k, n0, p0, u0;
            addr = 7'($urandom_range(8, 119));
            slave_addr = addr;
            match = ($urandom_range(0, 3) != 0);
            sent = match ? addr : (addr ^ 7'($urandom_range(1, 127)));
            rw = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            n0 = rx_got.size();
            p0 = tx_pops;
            u0 = underruns;
            exp_q.delete();
            ld.delete();
            tx_tail = tx_head;
            bus_start();
            write_byte({sent, rw}, ack);
            checks++; if (ack !== !match) begin errors++; $display("FAIL rand%0d_addr_ack: got %b expected %b", t, ack, !match); end
            if (!rw) begin
                blocked = !match;
                for (int i = 0; i < nb; i++) begin
                    d = 8'($urandom);
                    full = ($urandom_range(0, 3) == 0);
                    exp_ack = blocked || full;
                    if (!exp_ack) exp_q.push_back(d);
                    else blocked = 1'b1;
                    rx_full = full;
                    write_byte(d, ack);
                    rx_full = 1'b0;
                    checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand%0d_wr_ack%0d: got %b expected %b", t, i, ack, exp_ack); end
                end
            end else begin
                k = $urandom_range(0, nb);
                for (int i = 0; i < k; i++) begin
                    d = 8'($urandom);
                    ld.push_back(d);
                    tx_load(d);
                end
                for (int i = 0; i < nb; i++) begin
                    exp_d = (match && i < k) ? ld[i] : 8'hFF;
                    read_byte(d, (i == nb - 1));
                    checks++; if (d !== exp_d) begin errors++; $display("FAIL rand%0d_rd_byte%0d: got %h expected %h", t, i, d, exp_d); end
                end
                checks++; if (tx_pops - p0 !== (match ? k : 0)) begin errors++; $display("FAIL rand%0d_pops: got %0d expected %0d", t, tx_pops - p0, match ? k : 0); end
                checks++; if (underruns - u0 !== (match ? nb - k : 0)) begin errors++; $display("FAIL rand%0d_underruns: got %0d expected %0d", t, underruns - u0, match ? nb - k : 0); end
            end
            bus_stop();
            checks++; if (rx_got.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL rand%0d_push_count: got %0d expected %0d", t, rx_got.size() - n0, exp_q.size()); end
            else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (rx_got[n0+i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_push%0d: got %h expected %h", t, i, rx_got[n0+i], exp_q[i]); end
                end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_off: got %b expected 0", t, busy); end
            tx_tail = tx_head;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_rx_full();
        test_rep_start_underrun();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
